asg_frame_scheduler: RTL

Sequences azimuth pulse-pattern frames into the azimuth signal generator's DATA vector. It receives SIZE-bit frames as a 32-bit valid/ready word stream from the PS DMA and assembles them into a shadow buffer. On each radar trigger it swaps a completed shadow frame into the active DATA register. It sits between the DMA stream and the generator's DATA/EN inputs, and replaces the constant test pattern.

---
 rtl/asg_pkg.sv | 9 +
 rtl/asg_frame_assembler.sv | 52 +++++
 rtl/asg_frame_scheduler.sv | 69 ++++++
 3 files changed

// File: rtl/asg_pkg.sv
// asg_pkg: shared constants, fill-state encoding and frame sizing helper for the azimuth frame scheduler
package asg_pkg;
  localparam int AXIS_W = 32;
  localparam int SIZE_DEFAULT = 3200;
  typedef enum logic [1:0] {FILL, DROP, FULL} fill_state_t;
  function automatic int words_per_frame(input int size);
    return size / AXIS_W;
  endfunction
endpackage

// File: rtl/asg_frame_assembler.sv
// asg_frame_assembler: packs the 32-bit word stream LSB-first into a shadow frame and flags framing violations
module asg_frame_assembler
  import asg_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AXIS_W-1:0] tdata,
  input  logic              tvalid,
  input  logic              tlast,
  input  logic              clear_full,
  output logic              tready,
  output logic [SIZE-1:0]   shadow,
  output logic              shadow_full,
  output logic              frame_err
);
  localparam int WORDS = words_per_frame(SIZE);
  localparam int IDX_W = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);
  fill_state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic accept, at_last, fill_accept;
  // handshake and next fill state; ready drops during reset and while a complete frame waits for its swap
  always_comb begin
    tready = !rst && state != FULL;
    accept = tvalid && tready;
    at_last = idx == LAST;
    fill_accept = accept && state == FILL;
    state_nxt = state;
    if (state == FULL) state_nxt = clear_full ? FILL : FULL;
    else if (accept && state == DROP) state_nxt = tlast ? FILL : DROP;
    else if (fill_accept) state_nxt = at_last ? (tlast ? FULL : DROP) : FILL;
  end
  // fill state register
  always_ff @(posedge clk) state <= rst ? FILL : state_nxt;
  // word placement, index tracking, full flag and framing error pulse; a TLAST that disagrees with the index is an error
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      shadow_full <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= fill_accept && (tlast != at_last);
      shadow_full <= clear_full ? 1'b0 : (fill_accept && tlast && at_last) ? 1'b1 : shadow_full;
      if (fill_accept) begin
        shadow[idx*AXIS_W +: AXIS_W] <= tdata;
        idx <= (tlast || at_last) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/asg_frame_scheduler.sv
// asg_frame_scheduler: swaps DMA-assembled frames into the generator DATA vector on radar triggers; ASG_SCHED_REPEAT_EN repeats the last frame on underrun instead of blanking
module asg_frame_scheduler
  import asg_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              RADAR_TRIG_PE,
  input  logic              ENABLE,
  input  logic [AXIS_W-1:0] S_TDATA,
  input  logic              S_TVALID,
  input  logic              S_TLAST,
  output logic              S_TREADY,
  output logic [SIZE-1:0]   DATA_OUT,
  output logic              GEN_EN,
  output logic              FRAME_SWAP,
  output logic              UNDERRUN,
  output logic              FRAME_ERR,
  output logic [CNT_W-1:0]  UNDERRUN_CNT,
  output logic [31:0]       FRAME_CNT
);
  localparam int WORDS = words_per_frame(SIZE);
  if (WORDS * AXIS_W != SIZE) begin : g_size_check
    $error("asg_frame_scheduler: SIZE must be a multiple of 32");
  end
  logic [SIZE-1:0] shadow;
  logic shadow_full, trig, swap, under;
  asg_frame_assembler #(.SIZE(SIZE)) u_asm (
    .clk        (SYS_CLK),
    .rst        (SYS_RST),
    .tdata      (S_TDATA),
    .tvalid     (S_TVALID),
    .tlast      (S_TLAST),
    .clear_full (swap),
    .tready     (S_TREADY),
    .shadow     (shadow),
    .shadow_full(shadow_full),
    .frame_err  (FRAME_ERR)
  );
  // trigger qualification; SHADOW_FULL is registered so a same-cycle last word is not yet swappable
  always_comb begin
    trig = RADAR_TRIG_PE && ENABLE;
    swap = trig && shadow_full;
    under = trig && !shadow_full && GEN_EN;
  end
  // active frame, generator enable, event pulses and counters
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      DATA_OUT <= '0;
      GEN_EN <= 1'b0;
      FRAME_SWAP <= 1'b0;
      UNDERRUN <= 1'b0;
      UNDERRUN_CNT <= '0;
      FRAME_CNT <= '0;
    end else begin
      FRAME_SWAP <= swap;
      UNDERRUN <= under;
      GEN_EN <= swap || (GEN_EN && ENABLE);
      FRAME_CNT <= FRAME_CNT + 32'(swap);
      if (under && !(&UNDERRUN_CNT)) UNDERRUN_CNT <= UNDERRUN_CNT + 1'b1;
      if (swap) DATA_OUT <= shadow;
`ifndef ASG_SCHED_REPEAT_EN
      else if (under) DATA_OUT <= '0;
`endif
    end
  end
endmodule
